// File: rtl/mux_nbit_arb_reg_pkg.sv
// Shared definitions for the M-channel arbitrated N-bit output register.
// Contents: arbitration mode encodings and the source-index width helper.
package mux_nbit_arb_reg_pkg;

  localparam int unsigned PRIO_RR    = 0;  // round-robin starting after last grant
  localparam int unsigned PRIO_FIXED = 1;  // fixed priority, channel 0 highest

  // Width of a channel index for m channels (at least one bit).
  function automatic int unsigned sw_of(input int unsigned m);
    if (m < 2) return 1;
    return unsigned'($clog2(m));
  endfunction

endpackage

// File: rtl/mux_nbit_arb_reg_rr_pick.sv
// Combinational rotating priority picker.
// Ports:
//   req     - M-bit request vector
//   start   - channel index the scan begins at
//   gnt_c   - one-hot grant (zero when no request)
//   idx_c   - encoded index of the granted channel
//   any_c   - at least one request present
module mux_nbit_arb_reg_rr_pick
  import mux_nbit_arb_reg_pkg::*;
#(
  parameter int unsigned M  = 4,
  parameter int unsigned SW = 2
) (
  input  logic [M-1:0]  req,
  input  logic [SW-1:0] start,
  output logic [M-1:0]  gnt_c,
  output logic [SW-1:0] idx_c,
  output logic          any_c
);

  logic [2*M-1:0] dbl;
  logic [M-1:0]   rot;
  logic [SW-1:0]  k;
  logic [SW:0]    sum;

  // Rotate so that channel 'start' sits at bit 0, encode, then rotate back.
  always_comb begin
    dbl   = {req, req} >> start;
    rot   = dbl[M-1:0];
    k     = '0;
    any_c = 1'b0;
    for (int unsigned i = 0; i < M; i++) begin
      if (!any_c && rot[i]) begin
        any_c = 1'b1;
        k     = SW'(i);
      end
    end
    sum   = {1'b0, k} + {1'b0, start};
    idx_c = (sum >= (SW+1)'(M)) ? SW'(sum - (SW+1)'(M)) : SW'(sum);
    gnt_c = '0;
    for (int unsigned i = 0; i < M; i++) begin
      gnt_c[i] = any_c && (idx_c == SW'(i));
    end
  end

endmodule

// File: rtl/mux_nbit_arb_reg.sv
// M-channel valid/ready arbiter feeding one registered N-bit output stage.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   in_data/in_valid    - M producer channels, channel i at [i*N +: N]
//   in_ready            - one-hot ack of the channel taken this cycle
//   out_data/out_valid  - registered selected word
//   out_ready           - consumer accepts out_data this cycle
//   out_src             - channel index of out_data
//   busy                - held word or any pending request
module mux_nbit_arb_reg
  import mux_nbit_arb_reg_pkg::*;
#(
  parameter  int unsigned N         = 32,
  parameter  int unsigned M         = 4,
  parameter  int unsigned PRIO_MODE = PRIO_RR,
  localparam int unsigned SW        = sw_of(M)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [M*N-1:0]  in_data,
  input  logic [M-1:0]    in_valid,
  output logic [M-1:0]    in_ready,
  output logic [N-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SW-1:0]   out_src,
  output logic            busy
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] start;
  logic [SW-1:0] gidx;
  logic [SW-1:0] ptr_nxt;
  logic [M-1:0]  gnt;
  logic          any;
  logic          ld;
  logic          take;
  logic [N-1:0]  sel_data;

  // Fixed priority always scans from channel 0.
  assign start = (PRIO_MODE == PRIO_FIXED) ? '0 : ptr;

  mux_nbit_arb_reg_rr_pick #(
    .M  (M),
    .SW (SW)
  ) u_pick (
    .req   (in_valid),
    .start (start),
    .gnt_c (gnt),
    .idx_c (gidx),
    .any_c (any)
  );

  // Register may load when empty or being drained this same cycle.
  assign ld       = !out_valid || out_ready;
  assign take     = ld && any;
  assign in_ready = gnt & {M{take && rst_n}};
  assign busy     = out_valid || (|in_valid);

  // Select the granted channel's word.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (gidx == SW'(i)) sel_data = in_data[i*N +: N];
    end
  end

  assign ptr_nxt = (gidx == SW'(M-1)) ? '0 : gidx + SW'(1);

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_src   <= gidx;
      if (PRIO_MODE != PRIO_FIXED) ptr <= ptr_nxt;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mux_nbit_arb_reg.md
Name: mux_nbit_arb_reg

Overview:
Parametrised successor to the plain N-bit 4:1 select mux. Takes M independent N-bit channels with valid/ready handshakes and picks one per cycle by round-robin or fixed priority. The chosen word is captured in a single output register with its own valid/ready handshake. Used wherever several producers share one datapath bus, for example writeback or memory-request merge points.

Parameters:
N, 32, data width per channel in bits
M, 4, channel count; legal range 2..8
PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority with channel 0 highest
SW, $clog2(M), source-index width (derived; must not be overridden)

Ports:
clk        in   1      rising-edge clock
rst_n      in   1      synchronous reset, active low
in_data    in   M*N    channel i occupies bits [i*N +: N]
in_valid   in   M      channel i holds a word
in_ready   out  M      one-hot or zero; channel i's word is taken this cycle
out_data   out  N      registered selected word
out_valid  out  1      out_data holds a word
out_ready  in   1      consumer accepts out_data this cycle
out_src    out  SW     channel index of the word in out_data
busy       out  1      out_valid OR any in_valid bit set

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_data=0, out_src=0, round-robin pointer ptr=0.
  - in_ready is forced to 0 combinationally while rst_n=0.
  - Reset mid-operation drops the held word; no channel is acked.
- Load enable: ld = !out_valid | out_ready.
- Grant is combinational:
  - g = first i with in_valid[i]=1, scanning ptr, ptr+1, ... mod M.
  - In PRIO_MODE=1, the scan always starts at 0 and ptr is ignored.
- in_ready[g] = ld & |in_valid & rst_n. All other in_ready bits are 0. in_ready never asserts for a channel with in_valid=0.
- Transfer in (ld & |in_valid) at the clk edge:
  - out_data <= in_data[g]
  - out_src <= g
  - out_valid <= 1
  - ptr <= (g+1) mod M; wraps from M-1 to 0. In PRIO_MODE=1, ptr holds.
- Drain without refill (out_valid & out_ready & no in_valid): out_valid <= 0. out_data and out_src hold their last values.
- Stall (out_valid & !out_ready):
  - out_data, out_src and out_valid hold.
  - All in_ready bits are 0.
  - ptr holds.
- Simultaneous drain and refill in one cycle is required: full throughput of 1 word/cycle with no bubble.
- Latency: 1 cycle from an in_valid/in_ready handshake to out_valid.
- Producers must hold in_valid and in_data stable until acked. The block does not check this.
- Fairness: with all M channels continuously valid and out_ready=1, each channel is granted exactly once in every M consecutive transfers.
- Combinational paths: out_ready -> in_ready is permitted (no skid buffer). in_valid -> out_* is registered only.

Decomposition:
- Shared package: SW derivation helper, PRIO_MODE encodings (PRIO_RR=0, PRIO_FIXED=1).
- Sub-module rr_pick: M-bit request vector plus SW-bit start pointer in; one-hot grant plus encoded index out; purely combinational. It is implemented by rotating the request vector by the pointer, running a priority encode, then un-rotating.
- Data selection reuses the existing N-bit mux cells in a tree keyed by the encoded grant. Register stage and ptr are in the top module.

Test Plan:
1. Reset with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0. After release with out_ready=1, the first grant goes to channel 0 and out_src=0 one cycle later.
2. M=4, RR, all valid, data i=0xA0+i, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3; no bubbles; out_data matches.
3. Only channels 1 and 3 valid, ptr=2 -> grant 3, then 1, then 3; ptr wraps 3->0 and skips idle channels.
4. out_valid=1 with out_ready=0 for 5 cycles, channel 2 valid -> out_data/out_src frozen, in_ready=0 throughout. When out_ready rises, channel 2 is acked that same cycle and loaded on the next edge.
5. PRIO_MODE=1, channels 0 and 2 continuously valid -> channel 0 is granted every cycle and channel 2 starves. Dropping in_valid[0] gives channel 2 the grant that cycle.
6. rst_n pulsed low while out_valid=1 and a stall is pending -> out_valid=0 and ptr=0 next cycle; no in_ready during reset; normal operation resumes afterwards.
